// File: rtl/pc_unit.sv
// Program-counter unit: PC register, next-PC selection, return-address stack,
// trap/eret path with saved EPC, and misaligned-target rejection.
module pc_unit #(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = '0,
   parameter logic [WIDTH-1:0] TRAP_VEC  = 'h80,
   parameter int               RAS_DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         RST,
   input  logic                         pcWrite,
   input  logic [2:0]                   sel,
   input  logic [15:0]                  immd16,
   input  logic [25:0]                  immd26,
   input  logic [WIDTH-1:0]             rs,
   input  logic                         trap,
   output logic [WIDTH-1:0]             pc,
   output logic [WIDTH-1:0]             newpc,
   output logic [WIDTH-1:0]             epc,
   output logic [WIDTH-1:0]             ras_top,
   output logic [$clog2(RAS_DEPTH):0]   ras_count,
   output logic                         ras_match,
   output logic                         addr_err
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [WIDTH-1:0] FOUR = 'd4;
   localparam logic [CW-1:0]    FULL = CW'(RAS_DEPTH);

   localparam logic [2:0] SEL_NEXT   = 3'd0;
   localparam logic [2:0] SEL_REL    = 3'd1;
   localparam logic [2:0] SEL_ABS    = 3'd2;
   localparam logic [2:0] SEL_RS     = 3'd3;
   localparam logic [2:0] SEL_CALL   = 3'd4;
   localparam logic [2:0] SEL_RETURN = 3'd5;
   localparam logic [2:0] SEL_ERET   = 3'd6;

   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   // ptr addresses the next free slot; the top entry sits just below it.
   logic [PW-1:0]    ptr;
   logic [PW-1:0]    top_idx;
   logic [WIDTH-1:0] ext;
   logic [WIDTH-1:0] pc4;
   logic             misaligned;

   assign ext        = {{(WIDTH-16){immd16[15]}}, immd16};
   assign pc4        = pc + FOUR;
   assign top_idx    = ptr - PW'(1);
   assign misaligned = (newpc[1:0] != 2'b00);
   assign ras_top    = (ras_count != '0) ? ras_mem[top_idx] : '0;

   always_comb begin
      newpc = pc4;
      case (sel)
         SEL_REL:             newpc = pc4 + (ext << 2);
         SEL_ABS, SEL_CALL:   newpc = {pc[WIDTH-1:28], immd26, 2'b00};
         SEL_RS, SEL_RETURN:  newpc = rs;
         SEL_ERET:            newpc = epc;
         default:             newpc = pc4;
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         pc        <= RESET_VEC;
         epc       <= '0;
         ptr       <= '0;
         ras_count <= '0;
         ras_match <= 1'b0;
         addr_err  <= 1'b0;
      end else begin
         ras_match <= 1'b0;
         addr_err  <= 1'b0;
         if (trap) begin
            epc <= pc;
            pc  <= TRAP_VEC;
         end else if (pcWrite) begin
            if (misaligned) begin
               epc      <= pc;
               pc       <= TRAP_VEC;
               addr_err <= 1'b1;
            end else begin
               pc <= newpc;
               if (sel == SEL_CALL) begin
                  // When full, ptr already addresses the oldest entry.
                  ras_mem[ptr] <= pc4;
                  ptr          <= ptr + PW'(1);
                  if (ras_count != FULL) ras_count <= ras_count + CW'(1);
               end else if (sel == SEL_RETURN && ras_count != '0) begin
                  ptr       <= top_idx;
                  ras_count <= ras_count - CW'(1);
                  ras_match <= (ras_mem[top_idx] == rs);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: sequencing, relative jumps, RAS saturation and
// underflow, address-error trap, trap/eret and reset collisions.
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        RST;
   logic        pcWrite;
   logic [2:0]  sel;
   logic [15:0] immd16;
   logic [25:0] immd26;
   logic [31:0] rs;
   logic        trap;
   logic [31:0] pc, newpc, epc, ras_top;
   logic [2:0]  ras_count;
   logic        ras_match, addr_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   pc_unit dut (
      .clk(clk), .RST(RST), .pcWrite(pcWrite), .sel(sel),
      .immd16(immd16), .immd26(immd26), .rs(rs), .trap(trap),
      .pc(pc), .newpc(newpc), .epc(epc), .ras_top(ras_top),
      .ras_count(ras_count), .ras_match(ras_match), .addr_err(addr_err)
   );

   task automatic drive(input logic w, input logic [2:0] s, input logic [15:0] i16,
                        input logic [25:0] i26, input logic [31:0] r, input logic t);
      pcWrite = w; sel = s; immd16 = i16; immd26 = i26; rs = r; trap = t;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      drive(1'b0, 3'd0, 16'h0, 26'h0, 32'h0, 1'b0);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      tick();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
      n_checks++; if (epc !== 32'h0) begin n_fail++; $display("FAIL reset_epc got %h exp %h", epc, 32'h0); end
      n_checks++; if (ras_count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", ras_count); end
      n_checks++; if (ras_top !== 32'h0) begin n_fail++; $display("FAIL reset_top got %h exp 0", ras_top); end
      n_checks++; if (ras_match !== 1'b0 || addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got %b%b exp 00", ras_match, addr_err); end
      #1;
      n_checks++; if (newpc !== 32'h4) begin n_fail++; $display("FAIL reset_newpc got %h exp %h", newpc, 32'h4); end
   endtask

   task automatic test_next_ins();
      logic [31:0] exp_pc [3];
      exp_pc[0] = 32'h4; exp_pc[1] = 32'h8; exp_pc[2] = 32'hC;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 3'd0, 16'h0, 26'h0, 32'h0, 1'b0);
         tick();
         n_checks++; if (pc !== exp_pc[i]) begin n_fail++; $display("FAIL next_ins_%0d got %h exp %h", i, pc, exp_pc[i]); end
      end
   endtask

   task automatic test_rel_jmp();
      drive(1'b1, 3'd2, 16'h0, 26'h40, 32'h0, 1'b0);
      tick();
      n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL abs_jmp got %h exp %h", pc, 32'h100); end
      drive(1'b1, 3'd1, 16'hFFFF, 26'h0, 32'h0, 1'b0);
      #1;
      n_checks++; if (newpc !== 32'h100) begin n_fail++; $display("FAIL rel_newpc got %h exp %h", newpc, 32'h100); end
      tick();
      n_checks++; if (pc !== 32'h100) begin n_fail++; $display("FAIL rel_back got %h exp %h", pc, 32'h100); end
      drive(1'b1, 3'd1, 16'h0003, 26'h0, 32'h0, 1'b0);
      tick();
      n_checks++; if (pc !== 32'h110) begin n_fail++; $display("FAIL rel_fwd got %h exp %h", pc, 32'h110); end
      drive(1'b1, 3'd3, 16'h0, 26'h0, 32'hFFFF_FFFC, 1'b0);
      tick();
      n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL rs_jmp got %h exp %h", pc, 32'hFFFF_FFFC); end
      drive(1'b1, 3'd0, 16'h0, 26'h0, 32'h0, 1'b0);
      tick();
      n_checks++; if (pc !== 32'h0 || addr_err !== 1'b0) begin n_fail++; $display("FAIL pc_wrap got %h/%b exp 0/0", pc, addr_err); end
   endtask

   task automatic test_ras();
      logic [31:0] exp_ret [4];
      logic [31:0] tgt;
      exp_ret[0] = 32'h4004; exp_ret[1] = 32'h3004; exp_ret[2] = 32'h2004; exp_ret[3] = 32'h1004;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         tgt = 32'h1000 * (i + 1);
         drive(1'b1, 3'd4, 16'h0, tgt[27:2], 32'h0, 1'b0);
         tick();
         n_checks++; if (pc !== tgt) begin n_fail++; $display("FAIL call_pc_%0d got %h exp %h", i, pc, tgt); end
         n_checks++; if (ras_count !== ((i < 4) ? 3'(i + 1) : 3'd4)) begin n_fail++; $display("FAIL call_count_%0d got %0d", i, ras_count); end
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++; if (ras_top !== exp_ret[i]) begin n_fail++; $display("FAIL ras_top_%0d got %h exp %h", i, ras_top, exp_ret[i]); end
         drive(1'b1, 3'd5, 16'h0, 26'h0, exp_ret[i], 1'b0);
         tick();
         n_checks++; if (pc !== exp_ret[i]) begin n_fail++; $display("FAIL ret_pc_%0d got %h exp %h", i, pc, exp_ret[i]); end
         n_checks++; if (ras_match !== 1'b1) begin n_fail++; $display("FAIL ret_match_%0d got %b exp 1", i, ras_match); end
         n_checks++; if (ras_count !== 3'(3 - i)) begin n_fail++; $display("FAIL ret_count_%0d got %0d exp %0d", i, ras_count, 3 - i); end
      end
      drive(1'b1, 3'd5, 16'h0, 26'h0, 32'h4, 1'b0);
      tick();
      n_checks++; if (pc !== 32'h4) begin n_fail++; $display("FAIL underflow_pc got %h exp %h", pc, 32'h4); end
      n_checks++; if (ras_match !== 1'b0 || ras_count !== 3'd0) begin n_fail++; $display("FAIL underflow_state got %b/%0d exp 0/0", ras_match, ras_count); end
      n_checks++; if (ras_top !== 32'h0) begin n_fail++; $display("FAIL underflow_top got %h exp 0", ras_top); end
   endtask

   task automatic test_addr_err();
      do_reset();
      drive(1'b1, 3'd4, 16'h0, 26'h10, 32'h0, 1'b0);
      tick();
      n_checks++; if (pc !== 32'h40 || ras_count !== 3'd1) begin n_fail++; $display("FAIL err_setup got %h/%0d exp 40/1", pc, ras_count); end
      drive(1'b1, 3'd3, 16'h0, 26'h0, 32'h202, 1'b0);
      tick();
      n_checks++; if (pc !== 32'h80) begin n_fail++; $display("FAIL err_pc got %h exp %h", pc, 32'h80); end
      n_checks++; if (epc !== 32'h40) begin n_fail++; $display("FAIL err_epc got %h exp %h", epc, 32'h40); end
      n_checks++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL err_pulse got %b exp 1", addr_err); end
      n_checks++; if (ras_count !== 3'd1 || ras_top !== 32'h4) begin n_fail++; $display("FAIL err_ras got %0d/%h exp 1/4", ras_count, ras_top); end
      tick();
      n_checks++; if (addr_err !== 1'b0 || pc !== 32'h80) begin n_fail++; $display("FAIL err_drop got %b/%h exp 0/80", addr_err, pc); end
   endtask

   task automatic test_trap_eret();
      do_reset();
      drive(1'b1, 3'd2, 16'h0, 26'hC0, 32'h0, 1'b0);
      tick();
      n_checks++; if (pc !== 32'h300) begin n_fail++; $display("FAIL trap_setup got %h exp %h", pc, 32'h300); end
      drive(1'b1, 3'd4, 16'h0, 26'h10, 32'h0, 1'b1);
      tick();
      n_checks++; if (pc !== 32'h80 || epc !== 32'h300) begin n_fail++; $display("FAIL trap_pc_epc got %h/%h exp 80/300", pc, epc); end
      n_checks++; if (ras_count !== 3'd0 || addr_err !== 1'b0) begin n_fail++; $display("FAIL trap_no_push got %0d/%b exp 0/0", ras_count, addr_err); end
      drive(1'b1, 3'd6, 16'h0, 26'h0, 32'h0, 1'b0);
      tick();
      n_checks++; if (pc !== 32'h300 || epc !== 32'h300) begin n_fail++; $display("FAIL eret got %h/%h exp 300/300", pc, epc); end
   endtask

   task automatic test_reset_collision();
      drive(1'b1, 3'd4, 16'h0, 26'h100, 32'h0, 1'b0);
      tick();
      drive(1'b1, 3'd3, 16'h0, 26'h0, 32'h1, 1'b0);
      tick();
      n_checks++; if (addr_err !== 1'b1 || ras_count !== 3'd1) begin n_fail++; $display("FAIL coll_setup got %b/%0d exp 1/1", addr_err, ras_count); end
      drive(1'b1, 3'd4, 16'h0, 26'h100, 32'h0, 1'b1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      n_checks++; if (pc !== 32'h0 || epc !== 32'h0) begin n_fail++; $display("FAIL coll_pc_epc got %h/%h exp 0/0", pc, epc); end
      n_checks++; if (ras_count !== 3'd0 || ras_top !== 32'h0) begin n_fail++; $display("FAIL coll_ras got %0d/%h exp 0/0", ras_count, ras_top); end
      n_checks++; if (ras_match !== 1'b0 || addr_err !== 1'b0) begin n_fail++; $display("FAIL coll_pulses got %b%b exp 00", ras_match, addr_err); end
   endtask

   initial begin
      RST = 1'b1;
      drive(1'b0, 3'd0, 16'h0, 26'h0, 32'h0, 1'b0);
      @(negedge clk);
      test_reset();
      test_next_ins();
      test_rel_jmp();
      test_ras();
      test_addr_err();
      test_trap_eret();
      test_reset_collision();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
